rf_write_arbiter: RTL

Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback stage and the multi-cycle unit (mul/div) result bus. Results from the multi-cycle unit are buffered in a small FIFO whenever the port is taken. A per-register pending scoreboard raises stalls for decode-stage reads of registers with outstanding multi-cycle results. The block sits between WB/MCU and the register file.

---
 rtl/rf_write_arbiter_pkg.sv | 12 +
 rtl/rf_write_arbiter_mc_result_fifo.sv | 51 +++++
 rtl/rf_write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and the multi-cycle result entry type for the register-file
// write arbiter.
package rf_write_arbiter_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } mc_entry_t;
endpackage

// File: rtl/rf_write_arbiter_mc_result_fifo.sv
// Small in-order FIFO holding multi-cycle results that lost the write port.
module mc_result_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  mc_entry_t din_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output mc_entry_t head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    mc_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // A pop while full frees the slot only for the following cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// the multi-cycle unit, with a pending scoreboard driving decode stalls.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_valid_i,
    input  logic [REG_W-1:0]  wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mc_valid_i,
    output logic              mc_ready_o,
    input  logic [REG_W-1:0]  mc_reg_i,
    input  logic [DATA_W-1:0] mc_data_i,
    input  logic              issue_valid_i,
    input  logic [REG_W-1:0]  issue_reg_i,
    input  logic [REG_W-1:0]  rd_reg1_i,
    input  logic [REG_W-1:0]  rd_reg2_i,
    output logic              hazard_stall_o,
    output logic              rf_we_o,
    output logic [REG_W-1:0]  rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
);
    localparam int CNT_W = 5;

    logic [31:0]      pend_q, pend_d, set_vec, clr_vec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_take, mc_live, mc_acc, mc_drop, bypass;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             src_hit, issue_block, issue_acc;
    logic [1:0]       commits;
    mc_entry_t        head;

    mc_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .din_i   ({mc_reg_i, mc_data_i}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign wb_take    = wb_valid_i && (wb_reg_i != REG_ZERO);
    assign mc_live    = mc_valid_i && (mc_reg_i != REG_ZERO);
    assign fifo_pop   = !wb_take && !fifo_empty;
    assign bypass     = !wb_take && fifo_empty && mc_live;
    assign mc_ready_o = !fifo_full;
    assign mc_acc     = mc_valid_i && mc_ready_o;
    assign fifo_push  = mc_acc && mc_live && !bypass;
    // Reg-0 results complete the handshake but are never written or buffered.
    assign mc_drop    = mc_acc && !mc_live;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (wb_take) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_reg_i;
            rf_wdata_o = wb_data_i;
        end else if (fifo_pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head.rd;
            rf_wdata_o = head.data;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = mc_reg_i;
            rf_wdata_o = mc_data_i;
        end
    end

    assign src_hit = ((rd_reg1_i != REG_ZERO) && pend_q[rd_reg1_i]) ||
                     ((rd_reg2_i != REG_ZERO) && pend_q[rd_reg2_i]);
    assign issue_block = issue_valid_i &&
                         ((cnt_q == CNT_W'(MAX_OUT)) ||
                          ((issue_reg_i != REG_ZERO) && pend_q[issue_reg_i]));
    assign hazard_stall_o = src_hit || issue_block;
    assign issue_acc      = issue_valid_i && !hazard_stall_o;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_acc && (issue_reg_i != REG_ZERO)) set_vec[issue_reg_i] = 1'b1;
        if (fifo_pop) clr_vec[head.rd]  = 1'b1;
        if (bypass)   clr_vec[mc_reg_i] = 1'b1;
    end

    // Set wins over clear so a re-issue in the commit cycle stays tracked.
    assign pend_d  = (pend_q & ~clr_vec) | set_vec;
    assign commits = {1'b0, fifo_pop} + {1'b0, bypass} + {1'b0, mc_drop};
    assign cnt_d   = cnt_q + CNT_W'(issue_acc) - CNT_W'(commits);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    wb_to_pending_reg: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wb_take && pend_q[wb_reg_i]));
endmodule
